// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge: one APB transfer per AHB transfer, three select slots decoded on haddr[13:12].
// Optional feature: define DECODE_ERR_EN to answer unmapped accesses with a two-cycle AHB ERROR response.
module ahb_apb_bridge (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic        Hreadyin,
   input  logic [31:0] prdata,
   output logic [31:0] hrdata,
   output logic        Hreadyout,
   output logic [1:0]  hresp,
   output logic [2:0]  psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [31:0] pwdata
);

   // state     | meaning
   // ST_IDLE   | no transfer in flight, ready for an address phase
   // ST_WDATA  | write accepted, capturing hwdata from the AHB data phase
   // ST_SETUP  | APB setup phase (psel high, penable low)
   // ST_ACCESS | APB access phase (penable high), may accept the next transfer
   // ST_ERR1   | unmapped access, first ERROR cycle (hready low)
   // ST_ERR2   | unmapped access, second ERROR cycle (hready high)
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3
`ifdef DECODE_ERR_EN
      ,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
`endif
   } state_t;

   state_t      state, state_nxt;
   logic        take;
   logic        trans_active;
   logic        valid;
   logic        unmapped;
   logic [2:0]  sel_dec;
   logic [2:0]  psel_q;
   logic        pwrite_q;
   logic [31:0] paddr_q;
   logic [31:0] pwdata_q;
   logic        apb_active;

   assign trans_active = (htrans == 2'b10) || (htrans == 2'b11);
   assign valid        = hsel & Hreadyin & trans_active;
   assign unmapped     = (haddr[13:12] == 2'b11);

   always_comb begin
      sel_dec = 3'b000;
      case (haddr[13:12])
         2'b00:   sel_dec = 3'b001;
         2'b01:   sel_dec = 3'b010;
         2'b10:   sel_dec = 3'b100;
         default: sel_dec = 3'b000;
      endcase
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         ST_IDLE, ST_ACCESS: begin
            state_nxt = ST_IDLE;
            if (valid) begin
               if (unmapped) begin
`ifdef DECODE_ERR_EN
                  state_nxt = ST_ERR1;
`else
                  state_nxt = ST_IDLE;
`endif
               end else begin
                  take      = 1'b1;
                  state_nxt = hwrite ? ST_WDATA : ST_SETUP;
               end
            end
         end
         ST_WDATA:  state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
`ifdef DECODE_ERR_EN
         ST_ERR1:   state_nxt = ST_ERR2;
         ST_ERR2:   state_nxt = ST_IDLE;
`endif
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state    <= ST_IDLE;
         psel_q   <= 3'b000;
         pwrite_q <= 1'b0;
         paddr_q  <= 32'h0;
         pwdata_q <= 32'h0;
      end else begin
         state <= state_nxt;
         if (take) begin
            psel_q   <= sel_dec;
            pwrite_q <= hwrite;
            paddr_q  <= haddr;
         end
         if (state == ST_WDATA)
            pwdata_q <= hwdata;
      end
   end

   // APB control lines are only driven while a transfer is on the APB bus.
   assign apb_active = (state == ST_SETUP) || (state == ST_ACCESS);
   assign psel       = apb_active ? psel_q : 3'b000;
   assign penable    = (state == ST_ACCESS);
   assign pwrite     = apb_active & pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign hrdata     = ((state == ST_ACCESS) && !pwrite_q) ? prdata : 32'h0;

`ifdef DECODE_ERR_EN
   assign Hreadyout = !((state == ST_WDATA) || (state == ST_SETUP) || (state == ST_ERR1));
   assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
`else
   assign Hreadyout = !((state == ST_WDATA) || (state == ST_SETUP));
   assign hresp     = 2'b00;
`endif

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed table-driven bench for ahb_apb_bridge, plus hand sequences for unmapped access and reset abort.
module tb_ahb_apb_bridge;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [1:0]  htrans;
   logic        hwrite;
   logic        Hreadyin;
   logic [31:0] prdata;
   logic [31:0] hrdata;
   logic        Hreadyout;
   logic [1:0]  hresp;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;

   int checks = 0;
   int errors = 0;

   always #5 hclk = ~hclk;

   ahb_apb_bridge dut (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hwdata(hwdata),
      .htrans(htrans), .hwrite(hwrite), .Hreadyin(Hreadyin), .prdata(prdata),
      .hrdata(hrdata), .Hreadyout(Hreadyout), .hresp(hresp), .psel(psel),
      .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic        rin;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [2:0]  e_psel;
      logic        e_pen;
      logic        e_pwr;
      logic [31:0] e_paddr;
      logic [31:0] e_pwdata;
      logic        e_rdy;
      logic [1:0]  e_resp;
      logic [31:0] e_hrdata;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic rin, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [2:0] e_psel, input logic e_pen,
                               input logic e_pwr, input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                               input logic e_rdy, input logic [1:0] e_resp, input logic [31:0] e_hrdata);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.rin = rin; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.e_psel = e_psel; v.e_pen = e_pen;
      v.e_pwr = e_pwr; v.e_paddr = e_paddr; v.e_pwdata = e_pwdata;
      v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_hrdata = e_hrdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] e_psel, input logic e_pen,
                          input logic e_pwr, input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                          input logic e_rdy, input logic [1:0] e_resp, input logic [31:0] e_hrdata);
      chk({tag, " psel"},      {29'h0, psel},      {29'h0, e_psel});
      chk({tag, " penable"},   {31'h0, penable},   {31'h0, e_pen});
      chk({tag, " pwrite"},    {31'h0, pwrite},    {31'h0, e_pwr});
      chk({tag, " paddr"},     paddr,              e_paddr);
      chk({tag, " pwdata"},    pwdata,             e_pwdata);
      chk({tag, " Hreadyout"}, {31'h0, Hreadyout}, {31'h0, e_rdy});
      chk({tag, " hresp"},     {30'h0, hresp},     {30'h0, e_resp});
      chk({tag, " hrdata"},    hrdata,             e_hrdata);
   endtask

   task automatic drive(input logic sel, input logic [1:0] trans, input logic wr, input logic rin,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
      hsel = sel; htrans = trans; hwrite = wr; Hreadyin = rin;
      haddr = addr; hwdata = wdata; prdata = rdata;
   endtask

   task automatic step;
      @(posedge hclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            sel trans wr rin addr           wdata          rdata          psel   pen pwr paddr          pwdata         rdy resp  hrdata
      vecs[0]  = mk(1, 2'b00, 0, 1, 32'h0000_1000, 32'h0,         32'h0,         3'b000, 0, 0, 32'h0,         32'h0,         1, 2'b00, 32'h0);
      vecs[1]  = mk(1, 2'b10, 1, 0, 32'h0000_1000, 32'h0,         32'h0,         3'b000, 0, 0, 32'h0,         32'h0,         1, 2'b00, 32'h0);
      vecs[2]  = mk(0, 2'b10, 0, 1, 32'h0000_1000, 32'h0,         32'h0,         3'b000, 0, 0, 32'h0,         32'h0,         1, 2'b00, 32'h0);
      vecs[3]  = mk(1, 2'b01, 0, 1, 32'h0000_1000, 32'h0,         32'h0,         3'b000, 0, 0, 32'h0,         32'h0,         1, 2'b00, 32'h0);
      vecs[4]  = mk(1, 2'b10, 0, 1, 32'd32,        32'h0,         32'd40,        3'b001, 0, 0, 32'd32,        32'h0,         0, 2'b00, 32'h0);
      vecs[5]  = mk(1, 2'b00, 0, 1, 32'd32,        32'h0,         32'd40,        3'b001, 1, 0, 32'd32,        32'h0,         1, 2'b00, 32'd40);
      vecs[6]  = mk(1, 2'b00, 0, 1, 32'd32,        32'h0,         32'd40,        3'b000, 0, 0, 32'd32,        32'h0,         1, 2'b00, 32'h0);
      vecs[7]  = mk(1, 2'b10, 1, 1, 32'h0000_1000, 32'h1111_1111, 32'h0,         3'b000, 0, 0, 32'h0000_1000, 32'h0,         0, 2'b00, 32'h0);
      vecs[8]  = mk(1, 2'b00, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         3'b010, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 2'b00, 32'h0);
      vecs[9]  = mk(1, 2'b00, 0, 1, 32'h0000_1000, 32'h0,         32'h55,        3'b010, 1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 1, 2'b00, 32'h0);
      vecs[10] = mk(1, 2'b00, 0, 1, 32'h0000_1000, 32'h0,         32'h55,        3'b000, 0, 0, 32'h0000_1000, 32'hDEAD_BEEF, 1, 2'b00, 32'h0);
      vecs[11] = mk(1, 2'b10, 0, 1, 32'h0000_0010, 32'h0,         32'h0,         3'b001, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 2'b00, 32'h0);
      vecs[12] = mk(1, 2'b10, 1, 1, 32'h0000_1004, 32'h0,         32'hA5A5_A5A5, 3'b001, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 1, 2'b00, 32'hA5A5_A5A5);
      vecs[13] = mk(1, 2'b11, 0, 1, 32'h0000_2000, 32'h0,         32'h77,        3'b100, 0, 0, 32'h0000_2000, 32'hDEAD_BEEF, 0, 2'b00, 32'h0);
      vecs[14] = mk(1, 2'b00, 0, 1, 32'h0000_2000, 32'h0,         32'h77,        3'b100, 1, 0, 32'h0000_2000, 32'hDEAD_BEEF, 1, 2'b00, 32'h77);
      vecs[15] = mk(1, 2'b00, 0, 1, 32'h0000_2000, 32'h0,         32'h77,        3'b000, 0, 0, 32'h0000_2000, 32'hDEAD_BEEF, 1, 2'b00, 32'h0);
      vecs[16] = mk(1, 2'b10, 0, 1, 32'h0000_0000, 32'h0,         32'h42,        3'b001, 0, 0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 2'b00, 32'h0);
      vecs[17] = mk(1, 2'b00, 0, 1, 32'h0000_0000, 32'h0,         32'h42,        3'b001, 1, 0, 32'h0000_0000, 32'hDEAD_BEEF, 1, 2'b00, 32'h42);
      vecs[18] = mk(1, 2'b10, 1, 1, 32'h0000_1234, 32'h0,         32'h42,        3'b000, 0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 0, 2'b00, 32'h0);
      vecs[19] = mk(1, 2'b00, 0, 1, 32'h0000_1234, 32'hCAFE_F00D, 32'h0,         3'b010, 0, 1, 32'h0000_1234, 32'hCAFE_F00D, 0, 2'b00, 32'h0);
      vecs[20] = mk(1, 2'b00, 0, 1, 32'h0000_1234, 32'h0,         32'h99,        3'b010, 1, 1, 32'h0000_1234, 32'hCAFE_F00D, 1, 2'b00, 32'h0);
      vecs[21] = mk(1, 2'b00, 0, 1, 32'h0000_1234, 32'h0,         32'h99,        3'b000, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 1, 2'b00, 32'h0);

      hresetn = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1234_5678);
      #12;
      chk_all("reset", 3'b000, 0, 0, 32'h0, 32'h0, 1, 2'b00, 32'h0);
      @(negedge hclk);
      hresetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge hclk);
         drive(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].rin,
               vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].e_psel, vecs[i].e_pen, vecs[i].e_pwr,
                 vecs[i].e_paddr, vecs[i].e_pwdata, vecs[i].e_rdy, vecs[i].e_resp, vecs[i].e_hrdata);
      end

      // Unmapped write then read at 0x3000; paddr/pwdata must not pick up the unmapped access.
      @(negedge hclk);
      drive(1'b1, 2'b10, 1'b1, 1'b1, 32'h0000_3000, 32'h0, 32'h99);
      step();
`ifdef DECODE_ERR_EN
      chk_all("unmapped err1", 3'b000, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 0, 2'b01, 32'h0);
      @(negedge hclk);
      drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_3000, 32'h0BAD_0BAD, 32'h99);
      step();
      chk_all("unmapped err2", 3'b000, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 1, 2'b01, 32'h0);
      @(negedge hclk);
      drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'h99);
      step();
      chk_all("unmapped idle", 3'b000, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 1, 2'b00, 32'h0);
`else
      chk_all("unmapped wr", 3'b000, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 1, 2'b00, 32'h0);
      @(negedge hclk);
      drive(1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_3000, 32'h0BAD_0BAD, 32'h99);
      step();
      chk_all("unmapped rd", 3'b000, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 1, 2'b00, 32'h0);
      @(negedge hclk);
      drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'h99);
      step();
      chk_all("unmapped after", 3'b000, 0, 0, 32'h0000_1234, 32'hCAFE_F00D, 1, 2'b00, 32'h0);
`endif

      // Reset asserted during SETUP: outputs clear without a clock, and no ACCESS follows.
      @(negedge hclk);
      drive(1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 32'h66);
      step();
      chk_all("pre-reset setup", 3'b100, 0, 0, 32'h0000_2000, 32'hCAFE_F00D, 0, 2'b00, 32'h0);
      drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_2000, 32'h0, 32'h66);
      #1;
      hresetn = 1'b0;
      #1;
      chk_all("async reset", 3'b000, 0, 0, 32'h0, 32'h0, 1, 2'b00, 32'h0);
      step();
      chk_all("held reset", 3'b000, 0, 0, 32'h0, 32'h0, 1, 2'b00, 32'h0);

      // First valid transfer is taken on the first rising edge after release.
      @(negedge hclk);
      hresetn = 1'b1;
      drive(1'b1, 2'b10, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h66);
      step();
      chk_all("post-reset setup", 3'b001, 0, 0, 32'h0000_0040, 32'h0, 0, 2'b00, 32'h0);
      @(negedge hclk);
      drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h66);
      step();
      chk_all("post-reset access", 3'b001, 1, 0, 32'h0000_0040, 32'h0, 1, 2'b00, 32'h66);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 SHALL have these ports: hclk  in  1  sole clock, all state changes on its rising edge.
REQ-002 SHALL have these ports: hresetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have these ports: hsel  in  1  AHB slave select for the bridge.
REQ-004 SHALL have these ports: haddr  in  32  AHB address; hwdata  in  32  AHB write data, valid in the data phase.
REQ-005 SHALL have these ports: htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ); hwrite  in  1  1=write.
REQ-006 SHALL have these ports: Hreadyin  in  1  AHB bus ready; prdata  in  32  APB read data.
REQ-007 SHALL have these ports: hrdata  out  32  read data; Hreadyout  out  1  bridge ready; hresp  out  2  00 OKAY, 01 ERROR.
REQ-008 SHALL have these ports: psel  out  3  one-hot APB select; penable  out  1; pwrite  out  1; paddr  out  32; pwdata  out  32.

Function
REQ-009 Valid transfer = hsel & Hreadyin & htrans[1]; sampled only when the state is IDLE, or ACCESS with Hreadyout=1.
REQ-010 IDLE/BUSY htrans, hsel=0 or Hreadyin=0: transfer ignored; bridge stays IDLE with Hreadyout=1, hresp=00.
REQ-011 On a valid transfer, SHALL register haddr, hwrite and the decoded select.
REQ-012 Address decode on haddr[13:12]: 00->psel=001, 01->psel=010, 10->psel=100, 11->unmapped.
REQ-013 States: IDLE, WDATA, SETUP, ACCESS (plus ERR1, ERR2 per REQ-028).
REQ-014 Read, address phase at cycle T: SETUP at T+1, then ACCESS at T+2, then IDLE or the next SETUP.
REQ-015 Write, address phase at cycle T: WDATA at T+1, in which hwdata is captured into pwdata at the end of the cycle; SETUP at T+2; ACCESS at T+3.
REQ-016 In SETUP: psel=registered decode, penable=0, paddr=registered haddr, pwrite=registered hwrite.
REQ-017 In ACCESS: psel, paddr, pwrite and pwdata unchanged from SETUP; penable=1; exactly one cycle, since there is no wait-state input.
REQ-018 Hreadyout=0 in WDATA and SETUP; Hreadyout=1 in IDLE and ACCESS.
REQ-019 hrdata=prdata combinationally in ACCESS of a read; 0 otherwise.
REQ-020 In IDLE: psel=000, penable=0, pwrite=0; paddr and pwdata hold their last values.
REQ-021 A valid transfer sampled in ACCESS SHALL go directly to SETUP (read) or WDATA (write), with no IDLE cycle between.
REQ-022 Valid transfers presented while Hreadyout=0 SHALL be ignored.
REQ-023 Unmapped address without DECODE_ERR_EN: no APB activity; zero-wait OKAY; hrdata=0; write data discarded.
REQ-024 Every APB transfer SHALL assert exactly one psel bit; penable SHALL never be 1 without a psel bit.

Reset
REQ-025 On hresetn=0, immediately and asynchronously: state=IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; Hreadyout=1; hresp=00; hrdata=0.
REQ-026 A reset asserted mid-transfer SHALL abort the transfer with no completion.
REQ-027 The first valid transfer SHALL be sampled on the first rising edge with hresetn=1.

Configuration
REQ-028 With macro DECODE_ERR_EN defined, an unmapped access SHALL go to ERR1 (Hreadyout=0, hresp=01), then ERR2 (Hreadyout=1, hresp=01), then IDLE, with no psel asserted.
REQ-029 With DECODE_ERR_EN undefined, ERR1/ERR2 SHALL not exist; REQ-023 applies and hresp SHALL be constantly 00.

Verification
REQ-030 Read: hsel=1, Hreadyin=1, htrans=10, hwrite=0, haddr=32, prdata=40 -> SETUP cycle (psel=001, penable=0, paddr=32), then ACCESS (penable=1, Hreadyout=1, hrdata=40).
REQ-031 Write: haddr=0x1000, hwrite=1, hwdata=0xDEADBEEF on the next cycle -> psel=010, pwrite=1, pwdata=0xDEADBEEF, penable=1 at T+3; Hreadyout=0 at T+1 and T+2.
REQ-032 Back-to-back: read at 0x2000 accepted in ACCESS of a preceding read -> SETUP follows ACCESS directly, psel=100.
REQ-033 Idle/ignored: htrans=00 or Hreadyin=0 with hsel=1 -> psel=000, Hreadyout=1, hresp=00.
REQ-034 Reset: drive hresetn=0 during SETUP -> all outputs go to reset values before the next clock edge; no ACCESS follows.
REQ-035 Unmapped: haddr=0x3000 -> with DECODE_ERR_EN, hresp=01 for two cycles with Hreadyout 0 then 1; without it, zero-wait OKAY and psel=000.
